// File: rtl/life_pkg.sv
// Shared encodings for the life generation sequencer: status codes, FSM states
// and the default array geometry.
package life_pkg;

  localparam int LIFE_DEF_WIDTH  = 20;
  localparam int LIFE_DEF_HEIGHT = 20;

  localparam logic [2:0] STAT_RUN     = 3'd0;
  localparam logic [2:0] STAT_EXTINCT = 3'd1;
  localparam logic [2:0] STAT_STILL   = 3'd2;
  localparam logic [2:0] STAT_LIMIT   = 3'd3;
  localparam logic [2:0] STAT_OSC2    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SHOW   = 3'd3,
    S_PAUSE  = 3'd4,
    S_STEP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

endpackage

// File: rtl/life_seed_loader.sv
// Seed loader: accepts one seed row per valid/ready handshake and assembles the
// full cell_init image; done pulses on the handshake of the last row.
module life_seed_loader
  import life_pkg::*;
#(
  parameter int WIDTH  = LIFE_DEF_WIDTH,
  parameter int HEIGHT = LIFE_DEF_HEIGHT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    seed_valid,
  input  logic [WIDTH-1:0]        seed_row,
  output logic                    seed_ready,
  output logic [WIDTH*HEIGHT-1:0] cell_init,
  output logic                    done
);

  localparam int PW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [PW-1:0]           r_row_ptr;
  logic [WIDTH*HEIGHT-1:0] r_cell_init;
  logic                    w_accept;

  // A row transfers when seed_valid and seed_ready are both high on a rising
  // edge; clear (restart) suppresses the transfer in that cycle.
  assign seed_ready = enable;
  assign w_accept   = enable && seed_valid && !clear;
  assign done       = w_accept && (r_row_ptr == PW'(HEIGHT - 1));
  assign cell_init  = r_cell_init;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row_ptr   <= '0;
      r_cell_init <= '0;
    end else if (clear) begin
      r_row_ptr <= '0;
    end else if (w_accept) begin
      r_cell_init[r_row_ptr*WIDTH +: WIDTH] <= seed_row;
      r_row_ptr <= done ? '0 : r_row_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// Generation sequencer for the toroidal life array: loads the seed, strobes the
// array and paces frames to a display. Optional OSC2 detection: LIFE_GEN_SEQUENCER_OSC2_EN.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int WIDTH     = LIFE_DEF_WIDTH,
  parameter int HEIGHT    = LIFE_DEF_HEIGHT,
  parameter int GEN_W     = 16,
  parameter int ARRAY_LAT = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [WIDTH-1:0]        seed_row,
  input  logic                    run,
  input  logic                    step_req,
  input  logic [GEN_W-1:0]        gen_limit,
  input  logic [WIDTH*HEIGHT-1:0] states,
  output logic                    cell_load,
  output logic [WIDTH*HEIGHT-1:0] cell_init,
  output logic                    cell_step,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [GEN_W-1:0]        gen_count,
  output logic [2:0]              status,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int LW = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;

  state_t           r_state;
  logic             r_cell_load;
  logic             r_cell_step;
  logic             r_frame_valid;
  logic             r_busy;
  logic [GEN_W-1:0] r_gen;
  logic [2:0]       r_status;
  logic [N-1:0]     r_prev;
  logic             r_prev_vld;
  logic             r_step_pend;
  logic [LW-1:0]    r_settle;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
  logic [N-1:0]     r_prev2;
  logic             r_prev2_vld;
`endif

  logic       w_seed_done;
  logic       w_halt;
  logic [2:0] w_halt_code;
  logic       w_go_step;

  life_seed_loader #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_loader (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .enable     (r_state == S_IDLE),
    .seed_valid (seed_valid),
    .seed_row   (seed_row),
    .seed_ready (seed_ready),
    .cell_init  (cell_init),
    .done       (w_seed_done)
  );

  // Halt classification of the frame on display, highest priority first.
  always_comb begin
    w_halt      = 1'b1;
    w_halt_code = STAT_EXTINCT;
    if (states == '0)
      w_halt_code = STAT_EXTINCT;
    else if (r_prev_vld && states == r_prev)
      w_halt_code = STAT_STILL;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
    else if (r_prev2_vld && states == r_prev2 && states != r_prev)
      w_halt_code = STAT_OSC2;
`endif
    else if (gen_limit != '0 && r_gen >= gen_limit)
      w_halt_code = STAT_LIMIT;
    else
      w_halt = 1'b0;
  end

  assign w_go_step = run || r_step_pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cell_load   <= 1'b0;
      r_cell_step   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_gen         <= '0;
      r_status      <= STAT_RUN;
      r_prev        <= '0;
      r_prev_vld    <= 1'b0;
      r_step_pend   <= 1'b0;
      r_settle      <= '0;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
      r_prev2       <= '0;
      r_prev2_vld   <= 1'b0;
`endif
    end else begin
      r_cell_load <= 1'b0;
      r_cell_step <= 1'b0;
      if (restart) begin
        r_state       <= S_IDLE;
        r_frame_valid <= 1'b0;
        r_busy        <= 1'b0;
        r_gen         <= '0;
        r_status      <= STAT_RUN;
        r_step_pend   <= 1'b0;
      end else begin
        // r_busy mirrors "not IDLE and not HALT"; entering STEP below overrides.
        if (step_req && r_busy)
          r_step_pend <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_seed_done) begin
              r_state     <= S_LOAD;
              r_cell_load <= 1'b1;
              r_cell_step <= 1'b1;
              r_busy      <= 1'b1;
              r_gen       <= '0;
              r_prev_vld  <= 1'b0;
              r_status    <= STAT_RUN;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
              r_prev2_vld <= 1'b0;
`endif
            end
          end
          S_LOAD: begin
            r_state  <= S_SETTLE;
            r_settle <= '0;
          end
          S_SETTLE: begin
            if (r_settle == LW'(ARRAY_LAT - 1)) begin
              r_state       <= S_SHOW;
              r_frame_valid <= 1'b1;
            end else begin
              r_settle <= r_settle + 1'b1;
            end
          end
          S_SHOW: begin
            if (frame_ready) begin
              r_frame_valid <= 1'b0;
              if (w_halt) begin
                r_state  <= S_HALT;
                r_status <= w_halt_code;
                r_busy   <= 1'b0;
              end else begin
                r_prev     <= states;
                r_prev_vld <= 1'b1;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
                r_prev2     <= r_prev;
                r_prev2_vld <= r_prev_vld;
`endif
                if (w_go_step) begin
                  r_state     <= S_STEP;
                  r_cell_step <= 1'b1;
                  r_step_pend <= 1'b0;
                end else begin
                  r_state <= S_PAUSE;
                end
              end
            end
          end
          S_PAUSE: begin
            if (w_go_step) begin
              r_state     <= S_STEP;
              r_cell_step <= 1'b1;
              r_step_pend <= 1'b0;
            end
          end
          S_STEP: begin
            r_state  <= S_SETTLE;
            r_settle <= '0;
            r_gen    <= (&r_gen) ? r_gen : r_gen + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cell_load   = r_cell_load;
  assign cell_step   = r_cell_step;
  assign frame_valid = r_frame_valid;
  assign gen_count   = r_gen;
  assign status      = r_status;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer on a 5x5 torus with a behavioural life array
// (two-cycle latency) and a generation-level reference model.
`timescale 1ns/1ps
module tb_life_gen_sequencer;
  import life_pkg::*;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int N   = W * H;
  localparam int GW  = 8;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          restart = 1'b0;
  logic          seed_valid = 1'b0;
  logic [W-1:0]  seed_row = '0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic [GW-1:0] gen_limit = '0;
  logic          frame_ready = 1'b0;
  logic [N-1:0]  states;
  logic [N-1:0]  cell_init;
  logic          seed_ready, cell_load, cell_step, frame_valid, busy;
  logic [GW-1:0] gen_count;
  logic [2:0]    status, dbg_state;

  life_gen_sequencer #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW), .ARRAY_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .restart(restart),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_row(seed_row),
    .run(run), .step_req(step_req), .gen_limit(gen_limit), .states(states),
    .cell_load(cell_load), .cell_init(cell_init), .cell_step(cell_step),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .gen_count(gen_count), .status(status), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- life rule and array model ----------------
  function automatic logic [N-1:0] life_next(input logic [N-1:0] s);
    logic [N-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(s[((r + dr + H) % H) * W + ((c + dc + W) % W)]);
        n[r*W+c] = (cnt == 3) || (s[r*W+c] && cnt == 2);
      end
    return n;
  endfunction

  logic [N-1:0] arr_q;
  always @(posedge clock) begin
    if (cell_load)      arr_q <= cell_init;
    else if (cell_step) arr_q <= life_next(arr_q);
    states <= arr_q;
  end

  // ---------------- monitor ----------------
  int           n_steps = 0, n_loads = 0, n_viol = 0, since = 0;
  logic         last_step = 1'b0, last_load = 1'b0, last_fv = 1'b0;
  logic [N-1:0] last_states = '0;
  logic [N-1:0] frm_q[$];
  int           gen_q[$];

  always @(negedge clock) begin
    if ((cell_step && last_step) || (cell_load && last_load)) n_viol++;
    if (frame_valid && last_fv && states != last_states) n_viol++;
    if (cell_load) since = 0;
    else if (cell_step) begin
      since++;
      if (since > 1) n_viol++;
    end
    if (cell_step) n_steps++;
    if (cell_load) n_loads++;
    if (frame_valid && frame_ready) begin
      frm_q.push_back(states);
      gen_q.push_back(int'(gen_count));
      since = 0;
    end
    last_step   = cell_step;
    last_load   = cell_load;
    last_fv     = frame_valid;
    last_states = states;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_errors = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Generation-by-generation prediction of the frames shown and the halt reason.
  task automatic predict(input logic [N-1:0] seed, input int lim, output int hgen, output int hstat);
    logic [N-1:0] cur;
    int g;
    exp_q.delete();
    cur = seed; g = 0; hstat = 0; hgen = 0;
    while (g < 200) begin
      exp_q.push_back(cur);
      if (cur == '0) hstat = 1;
      else if (g >= 1 && cur == exp_q[g-1]) hstat = 2;
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
      else if (g >= 2 && cur == exp_q[g-2] && cur != exp_q[g-1]) hstat = 4;
`endif
      else if (lim != 0 && g >= lim) hstat = 3;
      if (hstat != 0) break;
      cur = life_next(cur);
      g++;
    end
    hgen = g;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  task automatic load_seed(input logic [N-1:0] img, input int rows);
    for (int r = 0; r < rows; r++) begin
      seed_valid = 1'b1;
      seed_row   = img[r*W +: W];
      tick();
      seed_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, input string tag);
    int k;
    k = 0;
    while (dbg_state != st && k < bound) begin tick(); k++; end
    check(tag, 64'(dbg_state == st), 64'd1);
  endtask

  task automatic wait_fv(input int bound, input string tag);
    int k;
    k = 0;
    while (!frame_valid && k < bound) begin tick(); k++; end
    check(tag, 64'(frame_valid), 64'd1);
  endtask

  task automatic run_scenario(input string tag, input logic [N-1:0] img, input int lim);
    int bf, bs, bl, bv, hgen, hstat, k;
    do_restart();
    run = 1'b1; gen_limit = GW'(lim); frame_ready = 1'b1;
    bf = frm_q.size(); bs = n_steps; bl = n_loads; bv = n_viol;
    predict(img, lim, hgen, hstat);
    load_seed(img, H);
    k = 0;
    while (dbg_state != S_HALT && k < 3000) begin
      frame_ready = ($urandom_range(0, 3) != 0);
      tick(); k++;
    end
    frame_ready = 1'b1;
    check({tag, "_halted"}, 64'(dbg_state == S_HALT), 64'd1);
    check({tag, "_status"}, 64'(status), 64'(hstat));
    check({tag, "_gen"}, 64'(gen_count), 64'(hgen));
    check({tag, "_frames"}, 64'(frm_q.size() - bf), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && bf + i < frm_q.size(); i++) begin
      check($sformatf("%s_frame%0d", tag, i), 64'(frm_q[bf+i]), 64'(exp_q[i]));
      check($sformatf("%s_fgen%0d", tag, i), 64'(gen_q[bf+i]), 64'(i));
    end
    check({tag, "_steps"}, 64'(n_steps - bs), 64'(hgen + 1));
    check({tag, "_loads"}, 64'(n_loads - bl), 64'd1);
    check({tag, "_strobe_rules"}, 64'(n_viol - bv), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_fv_low"}, 64'(frame_valid), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [N-1:0] img_single, img_block, img_blinker, img;
  logic [N-1:0] st_hold;
  int s0, fv_low, chg, k;
  logic seen;

  initial begin
    img_single  = '0; img_single[6] = 1'b1;
    img_block   = '0; img_block[6] = 1'b1; img_block[7] = 1'b1;
    img_block[11] = 1'b1; img_block[12] = 1'b1;
    img_blinker = '0; img_blinker[11] = 1'b1; img_blinker[12] = 1'b1; img_blinker[13] = 1'b1;

    #12;
    check("rst_seed_ready", 64'(seed_ready), 64'd1);
    check("rst_cell_load", 64'(cell_load), 64'd0);
    check("rst_cell_step", 64'(cell_step), 64'd0);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cell_init", 64'(cell_init), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clock); reset = 1'b1;
    tick();

    run_scenario("single", img_single, 0);
    run_scenario("block", img_block, 0);
    run_scenario("blinker", img_blinker, 3);
`ifdef LIFE_GEN_SEQUENCER_OSC2_EN
    check("blinker_osc2", 64'(status), 64'd4);
    check("blinker_osc2_gen", 64'(gen_count), 64'd2);
`else
    check("blinker_limit", 64'(status), 64'd3);
    check("blinker_limit_gen", 64'(gen_count), 64'd3);
`endif
    for (int i = 0; i < 4; i++)
      run_scenario($sformatf("rand%0d", i), N'($urandom), $urandom_range(1, 5));

    // Backpressure on the gen 1 frame.
    do_restart();
    run = 1'b1; frame_ready = 1'b0; gen_limit = '0;
    load_seed(img_blinker, H);
    wait_fv(50, "bp_frame0");
    frame_ready = 1'b1; tick(); frame_ready = 1'b0;
    wait_fv(50, "bp_frame1");
    check("bp_gen1", 64'(gen_count), 64'd1);
    s0 = n_steps; st_hold = states; fv_low = 0; chg = 0;
    repeat (10) begin
      tick();
      if (!frame_valid) fv_low++;
      if (states != st_hold) chg++;
    end
    check("bp_fv_held", 64'(fv_low), 64'd0);
    check("bp_no_step", 64'(n_steps - s0), 64'd0);
    check("bp_states_stable", 64'(chg), 64'd0);
    frame_ready = 1'b1; seen = 1'b0; k = 0;
    while (!seen && k < 6) begin tick(); if (cell_step) seen = 1'b1; k++; end
    check("bp_step_after_ready", 64'(seen), 64'd1);

    // Paused stepping: three requests while the frame is held coalesce.
    do_restart();
    run = 1'b0; frame_ready = 1'b0; gen_limit = '0;
    load_seed(img_blinker, H);
    wait_fv(50, "pause_frame0");
    s0 = n_steps;
    repeat (3) begin step_req = 1'b1; tick(); step_req = 1'b0; tick(); end
    check("pause_held_no_step", 64'(n_steps - s0), 64'd0);
    frame_ready = 1'b1;
    wait_state(S_PAUSE, 60, "pause_reached");
    check("pause_gen1", 64'(gen_count), 64'd1);
    check("pause_one_step", 64'(n_steps - s0), 64'd1);
    repeat (5) tick();
    check("pause_idle_steps", 64'(n_steps - s0), 64'd1);
    check("pause_still_paused", 64'(dbg_state), 64'(S_PAUSE));
    step_req = 1'b1; tick(); step_req = 1'b0;
    k = 0;
    while (dbg_state == S_PAUSE && k < 5) begin tick(); k++; end
    wait_state(S_PAUSE, 60, "pause_back");
    check("pause_gen2", 64'(gen_count), 64'd2);
    check("pause_two_steps", 64'(n_steps - s0), 64'd2);

    // Restart during SETTLE of generation 2.
    do_restart();
    run = 1'b1; frame_ready = 1'b1; gen_limit = '0;
    load_seed(img_blinker, H);
    k = 0;
    while (!(gen_count == 2 && dbg_state == S_SETTLE) && k < 200) begin tick(); k++; end
    check("rs_found_settle", 64'(gen_count == 2 && dbg_state == S_SETTLE), 64'd1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("rs_state", 64'(dbg_state), 64'(S_IDLE));
    check("rs_seed_ready", 64'(seed_ready), 64'd1);
    check("rs_gen", 64'(gen_count), 64'd0);
    check("rs_status", 64'(status), 64'd0);
    check("rs_strobes", 64'({cell_step, cell_load}), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a seed load.
    img = N'($urandom) | N'(5'h1F);
    load_seed(img, 2);
    check("ml_row0", 64'(cell_init[W-1:0]), 64'(img[W-1:0]));
    #2 reset = 1'b0;
    #1;
    check("ml_cell_init", 64'(cell_init), 64'd0);
    check("ml_state", 64'(dbg_state), 64'(S_IDLE));
    check("ml_seed_ready", 64'(seed_ready), 64'd1);
    @(negedge clock); reset = 1'b1;
    tick();

    check("global_strobe_rules", 64'(n_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
